// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/DM single-port RAM arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_t;

  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

  // Counter widths cover the legal ranges MEM_LAT 0..7 and STARVE_MAX 1..15.
  localparam int LAT_W    = 3;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: DM normally wins, IF wins alone or once DM has
// been granted STARVE_MAX times in a row while IF was waiting.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                if_req,
  input  logic                dm_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output req_id_t             winner,
  output logic                valid
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  // Priority decision; IF is the fallback winner when DM is not eligible.
  always_comb begin
    valid  = if_req | dm_req;
    winner = REQ_IF;
    if (dm_req && !(if_req && (starve_cnt == STARVE_LIM))) begin
      winner = REQ_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the instruction-fetch (IF) and the
// load/store (DM) paths with a registered request/grant/response FSM.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o
);

  localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(MEM_LAT);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_t              state_q, state_d;
  req_id_t             owner_q, owner_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic              if_gnt_d, dm_gnt_d, if_rvalid_d, dm_rvalid_d, we_d, busy_d;
  logic [DATA_W-1:0] if_rdata_d, dm_rdata_d, data_d;
  logic [ADDR_W-1:0] addr_d;

  req_id_t pick_winner;
  logic    pick_valid;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .if_req    (if_req_i),
    .dm_req    (dm_req_i),
    .starve_cnt(starve_q),
    .winner    (pick_winner),
    .valid     (pick_valid)
  );

  // Next-state and next-output logic; pulses default low, data defaults hold.
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_o;
    dm_rdata_d  = dm_rdata_o;
    we_d        = 1'b0;
    addr_d      = addr_o;
    data_d      = data_o;

    unique case (state_q)
      ST_IDLE: begin
        if (!if_req_i) starve_d = '0;
        if (pick_valid) begin
          owner_d = pick_winner;
          lat_d   = '0;
          if (pick_winner == REQ_DM) begin
            dm_gnt_d = 1'b1;
            addr_d   = dm_addr_i;
            if (if_req_i) begin
              starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 1'b1;
            end
            if (dm_we_i) begin
              we_d    = 1'b1;
              data_d  = dm_wdata_i;
              state_d = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end else begin
            if_gnt_d = 1'b1;
            addr_d   = if_addr_i;
            starve_d = '0;
            state_d  = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        addr_d  = '0;
        data_d  = '0;
        state_d = ST_IDLE;
      end
      ST_READ: begin
        if (lat_q == LAT_LAST) begin
          addr_d  = '0;
          state_d = ST_IDLE;
          if (owner_q == REQ_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = data_i;
          end else begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = data_i;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_IF;
      lat_q       <= '0;
      starve_q    <= '0;
      if_gnt_o    <= 1'b0;
      dm_gnt_o    <= 1'b0;
      if_rvalid_o <= 1'b0;
      dm_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      data_o      <= '0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      if_gnt_o    <= if_gnt_d;
      dm_gnt_o    <= dm_gnt_d;
      if_rvalid_o <= if_rvalid_d;
      dm_rvalid_o <= dm_rvalid_d;
      if_rdata_o  <= if_rdata_d;
      dm_rdata_o  <= dm_rdata_d;
      we_o        <= we_d;
      addr_o      <= addr_d;
      data_o      <= data_d;
      busy_o      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=1 main instance plus
// MEM_LAT=0 and MEM_LAT=3 instances for the load-latency cases.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  // Main instance (MEM_LAT=1, STARVE_MAX=4).
  logic        if_req, if_gnt, if_rvalid, dm_req, dm_we, dm_gnt, dm_rvalid, we, busy;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, addr, wdata, rdata;

  // Shared stimulus for the latency instances (loads only).
  logic        l_zero_bit, l_dm_req;
  logic [31:0] l_zero, l_addr;

  // MEM_LAT=0 instance outputs.
  logic        z_if_gnt, z_if_rvalid, z_dm_gnt, z_dm_rvalid, z_we, z_busy;
  logic [31:0] z_if_rdata, z_dm_rdata, z_addr, z_wdata, z_rdata;

  // MEM_LAT=3 instance outputs.
  logic        t_if_gnt, t_if_rvalid, t_dm_gnt, t_dm_rvalid, t_we, t_busy;
  logic [31:0] t_if_rdata, t_dm_rdata, t_addr, t_wdata, t_rdata;
  logic [31:0] m_p1, t_p1, t_p2, t_p3;

  // RAM contents: 0x100 holds an instruction, elsewhere {addr[15:0], ~addr[15:0]}.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0050_0093 : {a[15:0], ~a[15:0]};
  endfunction

  assign rdata   = m_p1;
  assign z_rdata = rom(z_addr);
  assign t_rdata = t_p3;

  always @(posedge clk) begin
    m_p1 <= rom(addr);
    t_p1 <= rom(t_addr);
    t_p2 <= t_p1;
    t_p3 <= t_p2;
  end

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .we_o(we), .addr_o(addr), .data_o(wdata), .data_i(rdata), .busy_o(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(0), .STARVE_MAX(4)) u_lat0 (
    .clk(clk), .reset(reset),
    .if_req_i(l_zero_bit), .if_addr_i(l_zero), .if_gnt_o(z_if_gnt),
    .if_rvalid_o(z_if_rvalid), .if_rdata_o(z_if_rdata),
    .dm_req_i(l_dm_req), .dm_we_i(l_zero_bit), .dm_addr_i(l_addr), .dm_wdata_i(l_zero),
    .dm_gnt_o(z_dm_gnt), .dm_rvalid_o(z_dm_rvalid), .dm_rdata_o(z_dm_rdata),
    .we_o(z_we), .addr_o(z_addr), .data_o(z_wdata), .data_i(z_rdata), .busy_o(z_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (
    .clk(clk), .reset(reset),
    .if_req_i(l_zero_bit), .if_addr_i(l_zero), .if_gnt_o(t_if_gnt),
    .if_rvalid_o(t_if_rvalid), .if_rdata_o(t_if_rdata),
    .dm_req_i(l_dm_req), .dm_we_i(l_zero_bit), .dm_addr_i(l_addr), .dm_wdata_i(l_zero),
    .dm_gnt_o(t_dm_gnt), .dm_rvalid_o(t_dm_rvalid), .dm_rdata_o(t_dm_rdata),
    .we_o(t_we), .addr_o(t_addr), .data_o(t_wdata), .data_i(t_rdata), .busy_o(t_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] order;
    int         n;
    logic       rv_seen;

    reset = 1'b1;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    l_zero_bit = 0; l_zero = '0; l_dm_req = 0; l_addr = '0;
    #1 reset = 1'b0;
    step(); step();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_addr", addr, 0);
    check("rst_we", {31'd0, we}, 0);
    check("rst_if_rdata", if_rdata, 0);
    reset = 1'b1;
    step();

    // Fetch with MEM_LAT=1.
    if_req = 1; if_addr = 32'h100;
    step();                                   // E0
    if_req = 0;
    check("fetch_gnt_e0", {31'd0, if_gnt}, 1);
    check("fetch_addr_e0", addr, 32'h100);
    check("fetch_busy_e0", {31'd0, busy}, 1);
    step();                                   // E1
    check("fetch_gnt_e1", {31'd0, if_gnt}, 0);
    check("fetch_addr_e1", addr, 32'h100);
    check("fetch_rvalid_e1", {31'd0, if_rvalid}, 0);
    step();                                   // E2
    check("fetch_rvalid_e2", {31'd0, if_rvalid}, 1);
    check("fetch_rdata_e2", if_rdata, 32'h0050_0093);
    check("fetch_addr_e2", addr, 0);
    check("fetch_busy_e2", {31'd0, busy}, 0);
    step();
    check("fetch_rvalid_e3", {31'd0, if_rvalid}, 0);

    // Store.
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
    step();                                   // E0
    dm_req = 0;
    check("store_gnt_e0", {31'd0, dm_gnt}, 1);
    check("store_we_e0", {31'd0, we}, 1);
    check("store_addr_e0", addr, 32'h2000);
    check("store_data_e0", wdata, 32'hDEAD_BEEF);
    step();                                   // E1
    check("store_we_e1", {31'd0, we}, 0);
    check("store_data_e1", wdata, 0);
    check("store_busy_e1", {31'd0, busy}, 0);
    check("store_rvalid_e1", {31'd0, dm_rvalid}, 0);
    step();
    check("store_rvalid_e2", {31'd0, dm_rvalid}, 0);

    // Simultaneous requests: DM load first, then IF.
    dm_we = 0; dm_addr = 32'h300; dm_req = 1;
    if_addr = 32'h104; if_req = 1;
    step();                                   // E0
    dm_req = 0;
    check("sim_dm_gnt", {31'd0, dm_gnt}, 1);
    check("sim_if_gnt_e0", {31'd0, if_gnt}, 0);
    step();
    check("sim_if_rdata_hold", if_rdata, 32'h0050_0093);
    step();                                   // DM response
    check("sim_dm_rvalid", {31'd0, dm_rvalid}, 1);
    check("sim_dm_rdata", dm_rdata, 32'h0300_FCFF);
    check("sim_if_rdata_hold2", if_rdata, 32'h0050_0093);
    step();                                   // IF grant
    if_req = 0;
    check("sim_if_gnt", {31'd0, if_gnt}, 1);
    check("sim_if_addr", addr, 32'h104);
    step(); step();
    check("sim_if_rvalid", {31'd0, if_rvalid}, 1);
    check("sim_if_rdata", if_rdata, 32'h0104_FEFB);

    // Saturated contention: both held high; IF wins every fifth grant.
    if_req = 1; if_addr = 32'h200;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2004; dm_wdata = 32'h11;
    n = 0; order = '0;
    for (int c = 0; c < 80 && n < 10; c++) begin
      step();
      if (dm_gnt && n < 10) begin order[n] = 1'b1; n++; end
      else if (if_gnt && n < 10) begin order[n] = 1'b0; n++; end
    end
    if_req = 0; dm_req = 0;
    check("cont_count", n, 10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("cont_order_%0d", k), {31'd0, order[k]},
            (k == 4 || k == 9) ? 32'd0 : 32'd1);
    end
    step(); step(); step(); step();

    // Reset one cycle after an IF grant aborts the read.
    if_req = 1; if_addr = 32'h108;
    step();                                   // E0
    if_req = 0;
    check("rst_mid_gnt", {31'd0, if_gnt}, 1);
    step();                                   // E1
    reset = 1'b0;
    #1;
    check("rst_mid_addr", addr, 0);
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_rdata", if_rdata, 0);
    rv_seen = if_rvalid | we;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 1) reset = 1'b1;
      rv_seen = rv_seen | if_rvalid | we;
    end
    check("rst_mid_no_rvalid", {31'd0, rv_seen}, 0);
    check("rst_mid_idle", {31'd0, busy}, 0);

    // DM load of 0x40 on MEM_LAT=0 and MEM_LAT=3 builds.
    l_dm_req = 1; l_addr = 32'h40;
    step();                                   // E0
    l_dm_req = 0;
    check("lat0_gnt", {31'd0, z_dm_gnt}, 1);
    check("lat3_gnt", {31'd0, t_dm_gnt}, 1);
    step();                                   // E0+1
    check("lat0_rvalid", {31'd0, z_dm_rvalid}, 1);
    check("lat0_rdata", z_dm_rdata, 32'h0040_FFBF);
    check("lat3_rvalid_e1", {31'd0, t_dm_rvalid}, 0);
    step();
    check("lat3_rvalid_e2", {31'd0, t_dm_rvalid}, 0);
    step();
    check("lat3_rvalid_e3", {31'd0, t_dm_rvalid}, 0);
    step();                                   // E0+4
    check("lat3_rvalid_e4", {31'd0, t_dm_rvalid}, 1);
    check("lat3_rdata", t_dm_rdata, 32'h0040_FFBF);
    check("lat3_busy_e4", {31'd0, t_busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
